reg_wb_queue: RTL and testbench
===============================

// Module: reg_wb_queue
// PURPOSE
//  Writer side of the register file's single write port (regwriteEn/regwriteaddr/regwritedata).
//  Accepts writeback requests from two producers (ALU path, memory/long-latency path) over
//  valid/ready, round-robin arbitrates, buffers them in a small in-order queue, drains one per cycle.
//  Exposes per-operand busy + forward data so decode can bypass queued results or stall.
// PARAMETERS
//  DEPTH  4   queue entries; power of 2, >=2
//  AW     5   register address width
//  DW     32  register data width
// PORTS
//  clk           in   1   clock, all state on posedge
//  rst           in   1   synchronous, active-high reset
//  aluwbvalid    in   1   ALU writeback request valid
//  aluwbready    out  1   ALU request accepted this cycle when valid&ready
//  aluwbaddr     in   AW  ALU destination register
//  aluwbdata     in   DW  ALU result
//  memwbvalid    in   1   memory-path writeback request valid
//  memwbready    out  1   memory request accepted when valid&ready
//  memwbaddr     in   AW  memory-path destination register
//  memwbdata     in   DW  memory-path result
//  wbhold        in   1   1 = do not drain this cycle (write port borrowed)
//  regwriteEn    out  1   register-file write enable
//  regwriteaddr  out  AW  register-file write address
//  regwritedata  out  DW  register-file write data
//  rsaddr        in   AW  decode operand A address
//  rtaddr        in   AW  decode operand B address
//  rsbusy        out  1   a queued write targets rsaddr
//  rtbusy        out  1   a queued write targets rtaddr
//  rsfwddata     out  DW  data of youngest queued entry matching rsaddr (0 if none)
//  rtfwddata     out  DW  data of youngest queued entry matching rtaddr (0 if none)
// BEHAVIOUR
//  - Reset (rst=1 at edge): queue empty, pointers/count 0, lastgrant=MEM (ALU wins first tie).
//    While rst=1: aluwbready=memwbready=0, regwriteEn=0, busy=0, fwddata=0.
//  - Readiness from registered count only (no same-cycle pass-through when full):
//    full -> both ready=0. Not full, one valid -> that source ready=1.
//    Both valid -> only source != lastgrant ready=1; lastgrant updates on every accepted grant.
//    Never more than one accept per cycle.
//  - Accepted request with addr==0: handshake completes, nothing enqueued, lastgrant still updates.
//  - Drain: regwriteEn = !empty & !wbhold; regwriteaddr/data = head entry (combinational from head;
//    0 when empty). Head pops at the edge where regwriteEn=1. Register file commits same edge.
//  - Latency: accept at edge N -> regwriteEn high in cycle N..N+1 -> committed at edge N+1
//    (empty queue, wbhold=0). wbhold only delays; order never changes.
//  - Simultaneous accept+pop: count unchanged; legal at any occupancy incl. full-1 and full.
//  - Pointers wrap modulo DEPTH; count width clog2(DEPTH+1).
//  - Lookup: scan all valid entries (head included, even if popping this cycle);
//    busy = (addr!=0) & any match; fwddata = youngest match. Same register queued twice
//    -> newer data wins. Incoming (not yet accepted) requests are not searched.
//  - rst mid-operation discards all queued entries; no write issued in the reset cycle.
// STRUCTURE
//  - Shared package mips_pkg: REG_AW=5, REG_DW=32, REG_ZERO=5'd0, wb_entry_t {addr,data},
//    WB_SRC_ALU/WB_SRC_MEM encoding for lastgrant.
//  - Sub-module wb_fifo: sync FIFO of wb_entry_t exposing all entries + per-slot valid and
//    age order for the lookup scan. Arbiter and lookup stay in reg_wb_queue.
// TESTING
//  - Reset: assert rst 2 cycles with both valids high -> readies 0, regwriteEn 0; first tie after
//    release grants ALU.
//  - Single write: ALU (addr=5,data=32'hDEAD_BEEF) on empty queue -> regwriteEn=1, addr 5,
//    next cycle; regfile r5 reads DEADBEEF after edge.
//  - Tie: both valid 4 cycles (ALU r1..r4, MEM r9..r12) -> accept order r1,r9,r2,r10,...; writes same order.
//  - Full/hold: wbhold=1, push DEPTH ALU writes -> aluwbready=0 at count=DEPTH; release -> DEPTH
//    writes back-to-back, FIFO order.
//  - Forward: queue r7=1 then r7=2 under wbhold; rsaddr=7 -> rsbusy=1, rsfwddata=2; rtaddr=0 -> rtbusy=0.
//  - Zero/reset: ALU addr=0 accepted -> no regwriteEn; rst with 3 queued -> no writes afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared register-file definitions for the MIPS datapath slice.
// Holds operand widths, the writeback entry layout and the writeback source encoding.
package mips_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback buffer. Besides the usual head/full/empty view it exposes every
// slot in age order (index 0 = oldest) with a valid bit so the owner can scan it.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  entry_t               push_entry,
    input  logic                 pop,
    output entry_t               head_entry,
    output logic                 empty,
    output logic                 full,
    output entry_t [DEPTH-1:0]   age_entry,
    output logic   [DEPTH-1:0]   age_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count_q;
    logic            push_ok;
    logic            pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // NOTE: storage is deliberately not reset; a slot is only meaningful while count covers it,
    // so clearing the pointers and count is enough to empty the buffer.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + PW'(1);
            end
            if (pop_ok) begin
                head <= head + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_entry = mem[head];

    // Pointers are power-of-two wide, so head+k wraps naturally onto the right slot.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entry[k] = mem[head + PW'(k)];
            age_valid[k] = (CW'(k) < count_q);
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// Owner of the register file's single write port: round-robin arbitration between the ALU
// and memory writeback paths, an in-order buffer that drains one write per cycle, and bypass lookup.
module reg_wb_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          aluwbvalid,
    output logic          aluwbready,
    input  logic [AW-1:0] aluwbaddr,
    input  logic [DW-1:0] aluwbdata,
    input  logic          memwbvalid,
    output logic          memwbready,
    input  logic [AW-1:0] memwbaddr,
    input  logic [DW-1:0] memwbdata,
    input  logic          wbhold,
    output logic          regwriteEn,
    output logic [AW-1:0] regwriteaddr,
    output logic [DW-1:0] regwritedata,
    input  logic [AW-1:0] rsaddr,
    input  logic [AW-1:0] rtaddr,
    output logic          rsbusy,
    output logic          rtbusy,
    output logic [DW-1:0] rsfwddata,
    output logic [DW-1:0] rtfwddata
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    wb_src_t              lastgrant;
    logic                 full;
    logic                 empty;
    logic                 alu_fire;
    logic                 mem_fire;
    logic                 push;
    logic                 pop;
    entry_t               push_entry;
    entry_t               head_entry;
    entry_t [DEPTH-1:0]   age_entry;
    logic   [DEPTH-1:0]   age_valid;

    // Readiness looks only at registered occupancy: a full buffer refuses even if it pops this cycle.
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned (no latch).
    always_comb begin
        aluwbready = 1'b0;
        memwbready = 1'b0;
        if (!rst && !full) begin
            aluwbready = aluwbvalid && (!memwbvalid || lastgrant == WB_SRC_MEM);
            memwbready = memwbvalid && (!aluwbvalid || lastgrant == WB_SRC_ALU);
        end
    end

    assign alu_fire = aluwbvalid && aluwbready;
    assign mem_fire = memwbvalid && memwbready;

    // A write to the zero register completes its handshake but never occupies a slot.
    assign push = (alu_fire && aluwbaddr != ZERO_ADDR) || (mem_fire && memwbaddr != ZERO_ADDR);

    always_comb begin
        push_entry.addr = alu_fire ? aluwbaddr : memwbaddr;
        push_entry.data = alu_fire ? aluwbdata : memwbdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastgrant <= WB_SRC_MEM;
        end else if (alu_fire) begin
            lastgrant <= WB_SRC_ALU;
        end else if (mem_fire) begin
            lastgrant <= WB_SRC_MEM;
        end
    end

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .empty      (empty),
        .full       (full),
        .age_entry  (age_entry),
        .age_valid  (age_valid)
    );

    assign pop          = !rst && !empty && !wbhold;
    assign regwriteEn   = pop;
    assign regwriteaddr = (rst || empty) ? '0 : head_entry.addr;
    assign regwritedata = (rst || empty) ? '0 : head_entry.data;

    // Scan oldest to youngest so the last hit left standing is the newest value for that register.
    always_comb begin
        rsbusy    = 1'b0;
        rtbusy    = 1'b0;
        rsfwddata = '0;
        rtfwddata = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && age_entry[k].addr == rsaddr) begin
                rsbusy    = 1'b1;
                rsfwddata = age_entry[k].data;
            end
            if (age_valid[k] && age_entry[k].addr == rtaddr) begin
                rtbusy    = 1'b1;
                rtfwddata = age_entry[k].data;
            end
        end
        if (rst || rsaddr == ZERO_ADDR) begin
            rsbusy    = 1'b0;
            rsfwddata = '0;
        end
        if (rst || rtaddr == ZERO_ADDR) begin
            rtbusy    = 1'b0;
            rtfwddata = '0;
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Scoreboard bench for reg_wb_queue: directed traffic pushes expected accepts and writes,
// a forked monitor compares handshakes and register-file writes as the DUT presents them.
module tb_reg_wb_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct packed {
        logic          src;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          aluwbvalid, aluwbready, memwbvalid, memwbready, wbhold;
    logic [AW-1:0] aluwbaddr, memwbaddr, rsaddr, rtaddr, regwriteaddr;
    logic [DW-1:0] aluwbdata, memwbdata, regwritedata, rsfwddata, rtfwddata;
    logic          regwriteEn, rsbusy, rtbusy;

    req_t alu_q[$];
    req_t mem_q[$];
    req_t wr_q[$];
    acc_t acc_q[$];

    logic [DW-1:0] rf [32];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .aluwbvalid   (aluwbvalid),
        .aluwbready   (aluwbready),
        .aluwbaddr    (aluwbaddr),
        .aluwbdata    (aluwbdata),
        .memwbvalid   (memwbvalid),
        .memwbready   (memwbready),
        .memwbaddr    (memwbaddr),
        .memwbdata    (memwbdata),
        .wbhold       (wbhold),
        .regwriteEn   (regwriteEn),
        .regwriteaddr (regwriteaddr),
        .regwritedata (regwritedata),
        .rsaddr       (rsaddr),
        .rtaddr       (rtaddr),
        .rsbusy       (rsbusy),
        .rtbusy       (rtbusy),
        .rsfwddata    (rsfwddata),
        .rtfwddata    (rtfwddata)
    );

    // Register file model committing on the same edge as the DUT drains.
    always @(posedge clk) begin
        if (regwriteEn) rf[regwriteaddr] <= regwritedata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, expected no event (t=%0t)", name, act, $time);
    endtask

    task automatic expect_acc(input logic src, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_q.push_back(acc_t'{src: src, addr: a, data: d});
        if (a != '0) wr_q.push_back(req_t'{addr: a, data: d});
    endtask

    task automatic check_accept(input logic src, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (acc_q.size() == 0) fail_unexpected("accept_unexpected", {src, a, d});
        else check("accept_order", {src, a, d}, acc_q.pop_front());
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (aluwbvalid && aluwbready && memwbvalid && memwbready)
                fail_unexpected("double_accept", {aluwbaddr, memwbaddr});
            if (aluwbvalid && aluwbready) check_accept(1'b0, aluwbaddr, aluwbdata);
            if (memwbvalid && memwbready) check_accept(1'b1, memwbaddr, memwbdata);
            if (regwriteEn) begin
                if (wr_q.size() == 0) fail_unexpected("write_unexpected", {regwriteaddr, regwritedata});
                else check("write_order", {regwriteaddr, regwritedata}, wr_q.pop_front());
            end
        end
    endtask

    // Producers present their queue fronts; called just after a rising edge.
    task automatic present();
        aluwbvalid = (alu_q.size() != 0);
        aluwbaddr  = aluwbvalid ? alu_q[0].addr : '0;
        aluwbdata  = aluwbvalid ? alu_q[0].data : '0;
        memwbvalid = (mem_q.size() != 0);
        memwbaddr  = memwbvalid ? mem_q[0].addr : '0;
        memwbdata  = memwbvalid ? mem_q[0].data : '0;
    endtask

    task automatic advance();
        logic af, mf;
        af = aluwbvalid && aluwbready;
        mf = memwbvalid && memwbready;
        @(posedge clk);
        #1;
        if (af) void'(alu_q.pop_front());
        if (mf) void'(mem_q.pop_front());
    endtask

    task automatic run_traffic(input int budget);
        int c = 0;
        while ((alu_q.size() != 0 || mem_q.size() != 0) && c < budget) begin
            present();
            @(negedge clk);
            advance();
            c++;
        end
        check("traffic_budget", alu_q.size() + mem_q.size(), 0);
        present();
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (wr_q.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_budget", wr_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wbhold = 1'b0;
        rsaddr = 5'd1;
        rtaddr = 5'd9;
        fork
            monitor_loop();
        join_none

        // Reset with both producers valid, then a tied stream: ALU must win the first tie.
        for (int i = 0; i < 4; i++) begin
            alu_q.push_back(req_t'{addr: AW'(1 + i), data: 32'hA000_0000 + 32'(1 + i)});
            mem_q.push_back(req_t'{addr: AW'(9 + i), data: 32'hB000_0000 + 32'(9 + i)});
            expect_acc(1'b0, AW'(1 + i), 32'hA000_0000 + 32'(1 + i));
            expect_acc(1'b1, AW'(9 + i), 32'hB000_0000 + 32'(9 + i));
        end
        present();
        repeat (2) begin
            @(negedge clk);
            check("rst_aluwbready", aluwbready, 0);
            check("rst_memwbready", memwbready, 0);
            check("rst_regwriteEn", regwriteEn, 0);
            check("rst_rsbusy", rsbusy, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        present();
        @(negedge clk);
        check("tie_first_alu_ready", aluwbready, 1);
        check("tie_first_mem_ready", memwbready, 0);
        advance();
        run_traffic(20);
        wait_drain(20);

        // Single write latency on an empty queue.
        alu_q.push_back(req_t'{addr: 5'd5, data: 32'hDEAD_BEEF});
        expect_acc(1'b0, 5'd5, 32'hDEAD_BEEF);
        present();
        @(negedge clk);
        check("single_ready", aluwbready, 1);
        check("single_idle_we", regwriteEn, 0);
        advance();
        present();
        @(negedge clk);
        check("single_we", regwriteEn, 1);
        check("single_addr", regwriteaddr, 5);
        check("single_data", regwritedata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("single_rf_r5", rf[5], 32'hDEAD_BEEF);
        check("single_we_after", regwriteEn, 0);
        @(posedge clk);
        #1;

        // Fill under hold, confirm full back-pressure, then drain back-to-back with an accept at full-1.
        wbhold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            alu_q.push_back(req_t'{addr: AW'(20 + i), data: 32'h1234_0000 + 32'(20 + i)});
            expect_acc(1'b0, AW'(20 + i), 32'h1234_0000 + 32'(20 + i));
        end
        run_traffic(10);
        alu_q.push_back(req_t'{addr: 5'd24, data: 32'h1234_0018});
        expect_acc(1'b0, 5'd24, 32'h1234_0018);
        rsaddr = 5'd22;
        present();
        @(negedge clk);
        check("full_ready", aluwbready, 0);
        check("hold_we", regwriteEn, 0);
        check("full_rsbusy", rsbusy, 1);
        check("full_rsfwd", rsfwddata, 32'h1234_0016);
        advance();
        wbhold = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            present();
            @(negedge clk);
            check("b2b_we", regwriteEn, 1);
            if (i == 0) check("full_ready_release", aluwbready, 0);
            advance();
        end
        present();
        wait_drain(10);

        // Forwarding: the newer of two queued writes to r7 wins; r0 is never busy.
        wbhold = 1'b1;
        rsaddr = 5'd7;
        rtaddr = 5'd0;
        alu_q.push_back(req_t'{addr: 5'd7, data: 32'd1});
        alu_q.push_back(req_t'{addr: 5'd7, data: 32'd2});
        expect_acc(1'b0, 5'd7, 32'd1);
        expect_acc(1'b0, 5'd7, 32'd2);
        run_traffic(10);
        @(negedge clk);
        check("fwd_rsbusy", rsbusy, 1);
        check("fwd_rsdata", rsfwddata, 2);
        check("fwd_rtbusy_r0", rtbusy, 0);
        check("fwd_rtdata_r0", rtfwddata, 0);
        #1 rtaddr = 5'd8;
        #1 check("fwd_rtbusy_r8", rtbusy, 0);
        rtaddr = 5'd7;
        #1 check("fwd_rtdata_r7", rtfwddata, 2);
        @(posedge clk);
        #1;
        wbhold = 1'b0;
        wait_drain(10);
        @(negedge clk);
        check("fwd_rsbusy_drained", rsbusy, 0);
        @(posedge clk);
        #1;

        // Zero-register write: accepted, not written, and still flips the round-robin pointer.
        alu_q.push_back(req_t'{addr: 5'd0, data: 32'h5555_5555});
        alu_q.push_back(req_t'{addr: 5'd16, data: 32'hA000_0010});
        mem_q.push_back(req_t'{addr: 5'd14, data: 32'hB000_000E});
        mem_q.push_back(req_t'{addr: 5'd15, data: 32'hB000_000F});
        expect_acc(1'b1, 5'd14, 32'hB000_000E);
        expect_acc(1'b0, 5'd0, 32'h5555_5555);
        expect_acc(1'b1, 5'd15, 32'hB000_000F);
        expect_acc(1'b0, 5'd16, 32'hA000_0010);
        run_traffic(10);
        wait_drain(10);

        // Reset with three entries queued: nothing may be written afterwards.
        wbhold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_q.push_back(req_t'{addr: AW'(25 + i), data: 32'hC000_0000 + 32'(25 + i)});
            expect_acc(1'b0, AW'(25 + i), 32'hC000_0000 + 32'(25 + i));
        end
        run_traffic(10);
        rsaddr = 5'd25;
        @(negedge clk);
        check("prerst_rsbusy", rsbusy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wbhold = 1'b0;
        wr_q.delete();
        @(negedge clk);
        check("rst_mid_we", regwriteEn, 0);
        check("rst_mid_rsbusy", rsbusy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("postrst_we", regwriteEn, 0);
            check("postrst_rsbusy", rsbusy, 0);
        end
        @(posedge clk);
        #1;

        check("accepts_outstanding", acc_q.size(), 0);
        check("writes_outstanding", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
